// File: rtl/operand_issue_pkg.sv
// Shared constants for the operand issue stage: default widths and lookup slots.
package operand_issue_pkg;

  localparam int unsigned DefRegCount    = 16;
  localparam int unsigned DefRegWidth    = 8;
  localparam int unsigned DefRegPtrWidth = 4;
  localparam int unsigned DefInsnWidth   = 16;
  localparam int unsigned DefSrcCount    = 3;
  localparam int unsigned DefLookups     = DefSrcCount + 1;

  // Scoreboard lookup slots: three sources followed by the destination.
  typedef enum logic [1:0] {
    LkSrc0 = 2'd0,
    LkSrc1 = 2'd1,
    LkSrc2 = 2'd2,
    LkDst  = 2'd3
  } lookup_e;

endpackage

// File: rtl/operand_issue_if.sv
// Issue-to-execute channel: valid/ready handshake with payload and resolved operands.
interface operand_issue_if #(
  parameter int unsigned REG_WIDTH     = operand_issue_pkg::DefRegWidth,
  parameter int unsigned REG_PTR_WIDTH = operand_issue_pkg::DefRegPtrWidth,
  parameter int unsigned INSN_WIDTH    = operand_issue_pkg::DefInsnWidth
);

  logic                     X_valid;
  logic                     X_ready;
  logic [INSN_WIDTH-1:0]    X_insn;
  logic [REG_PTR_WIDTH-1:0] X_dst;
  logic                     X_wr;
  logic [REG_WIDTH-1:0]     X_src_0_data;
  logic [REG_WIDTH-1:0]     X_src_1_data;
  logic [REG_WIDTH-1:0]     X_src_2_data;

  // Issue stage side.
  modport master (
    output X_valid, X_insn, X_dst, X_wr, X_src_0_data, X_src_1_data, X_src_2_data,
    input  X_ready
  );

  // Execute side.
  modport slave (
    input  X_valid, X_insn, X_dst, X_wr, X_src_0_data, X_src_1_data, X_src_2_data,
    output X_ready
  );

endinterface

// File: rtl/issue_scoreboard.sv
// Per-register pending-write scoreboard with set/clear ports and a busy lookup.
module issue_scoreboard
  import operand_issue_pkg::*;
#(
  parameter int unsigned REG_COUNT     = DefRegCount,
  parameter int unsigned REG_PTR_WIDTH = DefRegPtrWidth,
  parameter int unsigned LOOKUPS       = DefLookups
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  set_en,
  input  logic [REG_PTR_WIDTH-1:0]              set_ptr,
  input  logic                                  clr_en,
  input  logic [REG_PTR_WIDTH-1:0]              clr_ptr,
  input  logic [LOOKUPS-1:0][REG_PTR_WIDTH-1:0] lookup_ptr,
  output logic [LOOKUPS-1:0]                    busy,
  output logic [REG_COUNT-1:0]                  pending
);

  logic [REG_COUNT-1:0] pending_q, pending_d;

  // Next pending vector: clear first so a same-register set wins.
  always_comb begin
    pending_d = pending_q;
    if (clr_en) pending_d[clr_ptr] = 1'b0;
    if (set_en) pending_d[set_ptr] = 1'b1;
  end

  // A writeback landing this cycle already resolves its register.
  always_comb begin
    busy = '0;
    for (int unsigned i = 0; i < LOOKUPS; i++) begin
      busy[i] = pending_q[lookup_ptr[i]] & ~(clr_en & (clr_ptr == lookup_ptr[i]));
    end
  end

  // Pending state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pending_q <= '0;
    else          pending_q <= pending_d;
  end

  assign pending = pending_q;

endmodule

// File: rtl/operand_issue.sv
// Issue stage: holds one decoded instruction, resolves operands with writeback
// forwarding, stalls on RAW/WAW hazards and issues through a one-entry output register.
module operand_issue
  import operand_issue_pkg::*;
#(
  parameter int unsigned REG_COUNT     = DefRegCount,
  parameter int unsigned REG_WIDTH     = DefRegWidth,
  parameter int unsigned REG_PTR_WIDTH = DefRegPtrWidth
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     FD_valid,
  output logic                     FD_ready,
  input  logic [DefInsnWidth-1:0]  FD_insn,
  input  logic [REG_PTR_WIDTH-1:0] FD_insn_src_0,
  input  logic [REG_PTR_WIDTH-1:0] FD_insn_src_1,
  input  logic [REG_PTR_WIDTH-1:0] FD_insn_src_2,
  input  logic [DefSrcCount-1:0]   FD_src_used,
  input  logic [REG_PTR_WIDTH-1:0] FD_insn_dst,
  input  logic                     FD_insn_wr,
  input  logic [REG_WIDTH-1:0]     RF_src_0_data,
  input  logic [REG_WIDTH-1:0]     RF_src_1_data,
  input  logic [REG_WIDTH-1:0]     RF_src_2_data,
  output logic [REG_PTR_WIDTH-1:0] RF_src_0_ptr,
  output logic [REG_PTR_WIDTH-1:0] RF_src_1_ptr,
  output logic [REG_PTR_WIDTH-1:0] RF_src_2_ptr,
  input  logic [REG_PTR_WIDTH-1:0] MW_insn_dst,
  input  logic                     MW_wr,
  input  logic [REG_WIDTH-1:0]     W_result,
  input  logic                     init_R0,
  input  logic [REG_WIDTH-1:0]     init_R0_data,
  operand_issue_if.master          x
);

  // Held register H.
  logic                                     valid_h_q;
  logic [DefInsnWidth-1:0]                  h_insn_q;
  logic [DefSrcCount-1:0][REG_PTR_WIDTH-1:0] h_src_q;
  logic [DefSrcCount-1:0]                   h_used_q;
  logic [REG_PTR_WIDTH-1:0]                 h_dst_q;
  logic                                     h_wr_q;

  // Output register DX.
  logic                                     x_valid_q;
  logic [DefInsnWidth-1:0]                  x_insn_q;
  logic [REG_PTR_WIDTH-1:0]                 x_dst_q;
  logic                                     x_wr_q;
  logic [DefSrcCount-1:0][REG_WIDTH-1:0]    x_data_q;

  logic [DefSrcCount-1:0][REG_WIDTH-1:0]    rf_data;
  logic [DefSrcCount-1:0][REG_WIDTH-1:0]    opnd;
  logic [DefLookups-1:0][REG_PTR_WIDTH-1:0] lk_ptr;
  logic [DefLookups-1:0]                    sb_busy;
  logic [DefLookups-1:0]                    busy;
  logic                                     hazard;
  logic                                     issue;
  logic                                     accept;
  logic                                     x_fire;

  assign rf_data[0] = RF_src_0_data;
  assign rf_data[1] = RF_src_1_data;
  assign rf_data[2] = RF_src_2_data;

  assign RF_src_0_ptr = h_src_q[0];
  assign RF_src_1_ptr = h_src_q[1];
  assign RF_src_2_ptr = h_src_q[2];

  // Operand resolution: R0 init beats writeback forwarding, which beats the RF read.
  always_comb begin
    opnd = '0;
    for (int unsigned s = 0; s < DefSrcCount; s++) begin
      if (!h_used_q[s]) begin
        opnd[s] = '0;
      end else if (init_R0 && (h_src_q[s] == '0)) begin
        opnd[s] = init_R0_data;
      end else if (MW_wr && (MW_insn_dst == h_src_q[s])) begin
        opnd[s] = W_result;
      end else begin
        opnd[s] = rf_data[s];
      end
    end
  end

  // Scoreboard lookup pointers for the held instruction.
  always_comb begin
    lk_ptr         = '0;
    lk_ptr[LkSrc0] = h_src_q[0];
    lk_ptr[LkSrc1] = h_src_q[1];
    lk_ptr[LkSrc2] = h_src_q[2];
    lk_ptr[LkDst]  = h_dst_q;
  end

  assign x_fire = x_valid_q & x.X_ready;

  issue_scoreboard #(
    .REG_COUNT    (REG_COUNT),
    .REG_PTR_WIDTH(REG_PTR_WIDTH),
    .LOOKUPS      (DefLookups)
  ) u_scoreboard (
    .clk       (clk),
    .reset_n   (reset_n),
    .set_en    (x_fire & x_wr_q),
    .set_ptr   (x_dst_q),
    .clr_en    (MW_wr),
    .clr_ptr   (MW_insn_dst),
    .lookup_ptr(lk_ptr),
    .busy      (sb_busy),
    .pending   ()
  );

  // Hazard and handshake decisions; a writer sitting in DX counts as busy too.
  always_comb begin
    busy = '0;
    for (int unsigned i = 0; i < DefLookups; i++) begin
      busy[i] = sb_busy[i] | (x_valid_q & x_wr_q & (x_dst_q == lk_ptr[i]));
    end
    hazard   = (|(busy[DefSrcCount-1:0] & h_used_q)) | (h_wr_q & busy[LkDst]);
    issue    = valid_h_q & ~hazard & (~x_valid_q | x.X_ready) & ~flush;
    FD_ready = ~valid_h_q | issue;
    accept   = FD_valid & FD_ready & ~flush;
  end

  // Held register: load on accept, drop on issue or flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_h_q <= 1'b0;
      h_insn_q  <= '0;
      h_src_q   <= '0;
      h_used_q  <= '0;
      h_dst_q   <= '0;
      h_wr_q    <= 1'b0;
    end else begin
      if (flush)       valid_h_q <= 1'b0;
      else if (accept) valid_h_q <= 1'b1;
      else if (issue)  valid_h_q <= 1'b0;
      if (accept) begin
        h_insn_q  <= FD_insn;
        h_src_q   <= {FD_insn_src_2, FD_insn_src_1, FD_insn_src_0};
        h_used_q  <= FD_src_used;
        h_dst_q   <= FD_insn_dst;
        h_wr_q    <= FD_insn_wr;
      end
    end
  end

  // Output register: load on issue, hold while stalled by execute.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_valid_q <= 1'b0;
      x_insn_q  <= '0;
      x_dst_q   <= '0;
      x_wr_q    <= 1'b0;
      x_data_q  <= '0;
    end else begin
      if (flush)       x_valid_q <= 1'b0;
      else if (issue)  x_valid_q <= 1'b1;
      else if (x_fire) x_valid_q <= 1'b0;
      if (issue) begin
        x_insn_q <= h_insn_q;
        x_dst_q  <= h_dst_q;
        x_wr_q   <= h_wr_q;
        x_data_q <= opnd;
      end
    end
  end

  assign x.X_valid      = x_valid_q;
  assign x.X_insn       = x_insn_q;
  assign x.X_dst        = x_dst_q;
  assign x.X_wr         = x_wr_q;
  assign x.X_src_0_data = x_data_q[0];
  assign x.X_src_1_data = x_data_q[1];
  assign x.X_src_2_data = x_data_q[2];

endmodule
